dft_result_reader: RTL and testbench

DFT_RESULT_READER -- requirements
Module: dft_result_reader

---
 rtl/dft_result_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_dft_result_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_result_reader.sv
// dft_result_reader
// Streams the N result bins of a finished DFT out of the result RAM.
// A calc_end pulse in IDLE latches N = sample_num. The block then reads bins
// 0..N-1 from the RAM, which has one cycle of read latency. It presents each
// bin on a valid/ready stream, pulses done once the last bin has been
// accepted, and returns to IDLE.
//
// Ports
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   ce              : clock enable; all state and outputs hold while low
//   sample_num      : number of bins N, sampled on the accepted calc_end
//   calc_end        : start pulse (ignored while busy)
//   rd_en, rd_addr  : result RAM read request
//   rd_re, rd_im    : RAM read data, valid one ce-cycle after rd_en
//   out_valid/ready : output stream handshake
//   out_re, out_im  : bin result
//   out_index       : bin number k
//   out_last        : high with bin N-1
//   busy            : high from accepted start until the done cycle inclusive
//   done            : one ce-cycle pulse after the last bin is accepted
module dft_result_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              calc_end,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_re,
  input  logic [DATA_W-1:0] rd_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] n_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic              busy_r;
  logic              done_r;

  // Tag of the read currently travelling through the RAM (one-cycle latency).
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_idx_r;
  logic              inflight_last_r;

  // Two-entry FIFO: the head entry drives the outputs directly, and the skid
  // entry catches a returning word while the head is stalled.
  logic [1:0]        cnt_r;
  logic [DATA_W-1:0] head_re_r;
  logic [DATA_W-1:0] head_im_r;
  logic [ADDR_W-1:0] head_idx_r;
  logic              head_last_r;
  logic [DATA_W-1:0] skid_re_r;
  logic [DATA_W-1:0] skid_im_r;
  logic [ADDR_W-1:0] skid_idx_r;
  logic              skid_last_r;

  logic              pop_s;
  logic              push_s;
  logic [1:0]        occ_s;
  logic              issue_s;
  logic              issue_last_s;

  assign out_valid = (cnt_r != 2'd0);
  assign out_re    = head_re_r;
  assign out_im    = head_im_r;
  assign out_index = head_idx_r;
  assign out_last  = head_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_en     = issue_s;
  assign rd_addr   = rd_cnt_r;

  // Read issue decision and next-state logic.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    occ_s        = 2'd0;
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    state_s      = state_r;

    pop_s  = out_valid & out_ready;
    push_s = inflight_r;
    // Occupancy counts the head as free when it leaves this cycle. This is
    // what allows one read per cycle with only two entries of storage.
    occ_s        = cnt_r - {1'b0, pop_s} + {1'b0, inflight_r};
    issue_last_s = (rd_cnt_r == (n_r - {{(ADDR_W-1){1'b0}}, 1'b1}));

    if ((state_r == S_READ) && (rd_cnt_r != n_r) && (occ_s < 2'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    case (state_r)
      S_IDLE: begin
        if (calc_end) begin
          if (sample_num == {ADDR_W{1'b0}}) begin
            state_s = S_FINISH;
          end else begin
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s && issue_last_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_READ;
        end
      end
      S_DRAIN: begin
        if (pop_s && head_last_r) begin
          state_s = S_FINISH;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_FINISH: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Control state, bin counters and the in-flight read tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      n_r             <= {ADDR_W{1'b0}};
      rd_cnt_r        <= {ADDR_W{1'b0}};
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_idx_r  <= {ADDR_W{1'b0}};
      inflight_last_r <= 1'b0;
    end else if (ce) begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_FINISH);
      if ((state_r == S_IDLE) && calc_end) begin
        n_r      <= sample_num;
        rd_cnt_r <= {ADDR_W{1'b0}};
      end else if (issue_s) begin
        rd_cnt_r <= rd_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      inflight_r      <= issue_s;
      inflight_idx_r  <= rd_cnt_r;
      inflight_last_r <= issue_last_s;
    end
  end

  // Skid FIFO: push the returning RAM word, pop on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= 2'd0;
      head_re_r   <= {DATA_W{1'b0}};
      head_im_r   <= {DATA_W{1'b0}};
      head_idx_r  <= {ADDR_W{1'b0}};
      head_last_r <= 1'b0;
      skid_re_r   <= {DATA_W{1'b0}};
      skid_im_r   <= {DATA_W{1'b0}};
      skid_idx_r  <= {ADDR_W{1'b0}};
      skid_last_r <= 1'b0;
    end else if (ce) begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_re_r   <= rd_re;
            head_im_r   <= rd_im;
            head_idx_r  <= inflight_idx_r;
            head_last_r <= inflight_last_r;
          end else begin
            skid_re_r   <= rd_re;
            skid_im_r   <= rd_im;
            skid_idx_r  <= inflight_idx_r;
            skid_last_r <= inflight_last_r;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          if (cnt_r == 2'd2) begin
            head_re_r   <= skid_re_r;
            head_im_r   <= skid_im_r;
            head_idx_r  <= skid_idx_r;
            head_last_r <= skid_last_r;
          end else begin
            // FIFO becomes empty; do not leave a stale last flag behind.
            head_last_r <= 1'b0;
          end
          cnt_r <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            head_re_r   <= skid_re_r;
            head_im_r   <= skid_im_r;
            head_idx_r  <= skid_idx_r;
            head_last_r <= skid_last_r;
            skid_re_r   <= rd_re;
            skid_im_r   <= rd_im;
            skid_idx_r  <= inflight_idx_r;
            skid_last_r <= inflight_last_r;
          end else begin
            head_re_r   <= rd_re;
            head_im_r   <= rd_im;
            head_idx_r  <= inflight_idx_r;
            head_last_r <= inflight_last_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft_result_reader.sv
// Self-checking bench for dft_result_reader. A behavioural RAM holds
// re = base_re + stride_re*k and im = base_im + stride_im*k. The expected
// stream for N bins is simply k = 0..N-1 with those words, and last is set
// on k = N-1.
module tb_dft_result_reader;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic [AW-1:0] sample_num = '0;
  logic          calc_end = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_re = '0;
  logic [DW-1:0] rd_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  dft_result_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sample_num(sample_num), .calc_end(calc_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RAM contents and expected-word model
  logic [DW-1:0] base_re = '0, base_im = '0, stride_re = 32'd1, stride_im = 32'd1;
  function automatic logic [DW-1:0] word_re(input int k);
    return base_re + stride_re * DW'(k);
  endfunction
  function automatic logic [DW-1:0] word_im(input int k);
    return base_im + stride_im * DW'(k);
  endfunction

  // Result RAM with one ce-cycle read latency
  always @(posedge clk) begin
    if (ce && rd_en) begin
      rd_re <= word_re(int'(rd_addr));
      rd_im <= word_im(int'(rd_addr));
    end
  end

  // Trackers filled by the cycle driver
  int step_no = 0;
  int issued, exp_addr, addr_bad, stall_bad, freeze_bad, valid_seen;
  int done_cnt, busy_cnt, max_out, timed_out, post_busy, post_done;
  int calc_step, first_valid_step, first_xfer_step, last_xfer_step, done_step;
  logic [AW-1:0] got_idx[$];
  logic [DW-1:0] got_re[$];
  logic [DW-1:0] got_im[$];
  logic          got_last[$];
  logic          prev_hold, prev_ce;
  logic [2*DW+AW:0]   prev_word;
  logic [2*DW+2*AW+4:0] prev_snap;

  task automatic clear_trackers();
    issued = 0; exp_addr = 0; addr_bad = 0; stall_bad = 0; freeze_bad = 0;
    valid_seen = 0; done_cnt = 0; busy_cnt = 0; max_out = 0; timed_out = 0;
    post_busy = 0; post_done = 0; calc_step = -1; first_valid_step = -1;
    first_xfer_step = -1; last_xfer_step = -1; done_step = -1;
    got_idx.delete(); got_re.delete(); got_im.delete(); got_last.delete();
    prev_hold = 1'b0; prev_ce = 1'b1; prev_word = '0; prev_snap = '0;
  endtask

  // One clock: drive on the falling edge, observe 1 ns later, record events
  // that the following rising edge will commit.
  task automatic step(input logic ce_v, input logic rdy_v, input logic cal_v,
                      input logic [AW-1:0] sn);
    logic [2*DW+2*AW+4:0] snap;
    logic [2*DW+AW:0]     word;
    @(negedge clk);
    ce = ce_v; out_ready = rdy_v; calc_end = cal_v; sample_num = sn;
    #1;
    step_no++;
    snap = {rd_en, rd_addr, out_valid, out_re, out_im, out_index, out_last, busy, done};
    word = {out_re, out_im, out_index, out_last};
    if (prev_hold && (out_valid !== 1'b1 || word !== prev_word)) stall_bad++;
    if (!prev_ce && snap !== prev_snap) freeze_bad++;
    if (out_valid === 1'b1) begin
      valid_seen++;
      if (first_valid_step < 0) first_valid_step = step_no;
    end
    if (ce_v) begin
      if (rd_en === 1'b1) begin
        if (rd_addr !== exp_addr[AW-1:0]) addr_bad++;
        exp_addr++;
        issued++;
      end
      if (out_valid === 1'b1 && rdy_v) begin
        got_idx.push_back(out_index); got_re.push_back(out_re);
        got_im.push_back(out_im); got_last.push_back(out_last);
        if (first_xfer_step < 0) first_xfer_step = step_no;
        last_xfer_step = step_no;
      end
      if (done === 1'b1) begin done_cnt++; done_step = step_no; end
      if (busy === 1'b1) busy_cnt++;
    end
    if (issued - got_idx.size() > max_out) max_out = issued - got_idx.size();
    prev_hold = (out_valid === 1'b1) && !(ce_v && rdy_v);
    prev_word = word; prev_ce = ce_v; prev_snap = snap;
  endtask

  // Number of delivered words that differ from the expected stream 0..n-1
  function automatic int seq_bad(input int n);
    int bad = 0;
    for (int k = 0; k < got_idx.size(); k++) begin
      if (k >= n) bad++;
      else if (got_idx[k] !== k[AW-1:0] || got_re[k] !== word_re(k) ||
               got_im[k] !== word_im(k) || got_last[k] !== (k == n - 1)) bad++;
    end
    return bad;
  endfunction

  // One readout: rdy_mode 1 = random ready, ce_mode 1 = ce low every other
  // cycle, repulse = loop cycle where calc_end is re-pulsed with sample_num 9.
  task automatic run_stream(input int n, input int rdy_mode, input int ce_mode,
                            input int repulse, input int budget);
    int i;
    logic c, r, p;
    clear_trackers();
    step(1'b1, 1'b1, 1'b1, n[AW-1:0]);
    calc_step = step_no;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      i++;
      c = (ce_mode == 1) ? (i % 2 == 0) : 1'b1;
      r = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      p = (i == repulse);
      step(c, r, p, p ? 12'd9 : 12'($urandom));
    end
    if (done_cnt == 0) timed_out = 1;
    step(1'b1, 1'b1, 1'b0, 12'd0);
    post_busy = int'(busy); post_done = int'(done);
    step(1'b1, 1'b1, 1'b0, 12'd0);
    step(1'b1, 1'b1, 1'b0, 12'd0);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; ce = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_index !== '0) begin errors++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
    checks++; if ({out_re, out_im} !== '0) begin errors++; $display("FAIL reset_out_data: got %h %h want 0", out_re, out_im); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    base_re = 32'h10; base_im = 32'h20; stride_re = 32'd1; stride_im = 32'd1;
    run_stream(4, 0, 0, -1, 40);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++; if (got_idx.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_idx.size()); end
    checks++; if (seq_bad(4) != 0) begin errors++; $display("FAIL basic_seq: %0d bad words want 0", seq_bad(4)); end
    // first out_valid appears two edges after the edge that samples calc_end
    checks++; if (first_valid_step - calc_step != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", first_valid_step - calc_step); end
    checks++; if (last_xfer_step - first_xfer_step != 3) begin errors++; $display("FAIL basic_throughput: got %0d want 3", last_xfer_step - first_xfer_step); end
    checks++; if (done_step - last_xfer_step != 1) begin errors++; $display("FAIL basic_done_timing: got %0d want 1", done_step - last_xfer_step); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (post_busy != 0 || post_done != 0) begin errors++; $display("FAIL basic_post: busy %0d done %0d want 0 0", post_busy, post_done); end
    checks++; if (issued != 4 || addr_bad != 0) begin errors++; $display("FAIL basic_reads: issued %0d bad %0d want 4 0", issued, addr_bad); end
  endtask

  task automatic test_backpressure();
    base_re = $urandom; base_im = $urandom; stride_re = 32'd7; stride_im = 32'd13;
    run_stream(8, 1, 0, -1, 300);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout: no done within budget"); end
    checks++; if (got_idx.size() != 8 || seq_bad(8) != 0) begin errors++; $display("FAIL bp_seq: count %0d bad %0d want 8 0", got_idx.size(), seq_bad(8)); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d want <=2", max_out); end
    checks++; if (issued != 8 || addr_bad != 0) begin errors++; $display("FAIL bp_reads: issued %0d bad %0d want 8 0", issued, addr_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero();
    run_stream(0, 0, 0, -1, 20);
    checks++; if (issued != 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", issued); end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
    checks++; if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy: got %0d cycles want 1", busy_cnt); end
  endtask

  task automatic test_ce_gap();
    base_re = $urandom; base_im = $urandom; stride_re = 32'd3; stride_im = 32'd5;
    run_stream(5, 0, 1, -1, 80);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL ce_timeout: no done within budget"); end
    checks++; if (got_idx.size() != 5 || seq_bad(5) != 0) begin errors++; $display("FAIL ce_seq: count %0d bad %0d want 5 0", got_idx.size(), seq_bad(5)); end
    checks++; if (freeze_bad != 0) begin errors++; $display("FAIL ce_freeze: got %0d changes on ce=0 want 0", freeze_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ce_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_single();
    base_re = $urandom; base_im = $urandom;
    run_stream(1, 1, 0, -1, 60);
    checks++; if (got_idx.size() != 1 || seq_bad(1) != 0) begin errors++; $display("FAIL single_seq: count %0d bad %0d want 1 0", got_idx.size(), seq_bad(1)); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    base_re = $urandom; base_im = $urandom; stride_re = 32'd1; stride_im = 32'd2;
    run_stream(3, 1, 0, 2, 80);
    checks++; if (got_idx.size() != 3 || seq_bad(3) != 0) begin errors++; $display("FAIL restart_seq: count %0d bad %0d want 3 0", got_idx.size(), seq_bad(3)); end
    checks++; if (issued != 3) begin errors++; $display("FAIL restart_reads: got %0d want 3", issued); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int i;
    base_re = $urandom; base_im = $urandom;
    clear_trackers();
    step(1'b1, 1'b1, 1'b1, 12'd6);
    i = 0;
    while (got_idx.size() < 2 && i < 40) begin i++; step(1'b1, 1'b1, 1'b0, 12'd0); end
    checks++; if (got_idx.size() != 2) begin errors++; $display("FAIL abort_reach: got %0d words want 2", got_idx.size()); end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 12'd0);
    rst = 1'b0;
    checks++; if ({rd_en, rd_addr, out_valid, out_last, out_index, out_re, out_im, busy, done} !== '0) begin
      errors++; $display("FAIL abort_reset: valid %b idx %0d busy %b done %b rd_en %b want all 0", out_valid, out_index, busy, done, rd_en);
    end
    clear_trackers();
    for (int j = 0; j < 8; j++) step(1'b1, 1'b1, 1'b0, 12'd0);
    checks++; if (done_cnt != 0 || valid_seen != 0 || issued != 0) begin errors++; $display("FAIL abort_quiet: done %0d valid %0d reads %0d want 0 0 0", done_cnt, valid_seen, issued); end
    run_stream(3, 0, 0, -1, 40);
    checks++; if (got_idx.size() != 3 || seq_bad(3) != 0) begin errors++; $display("FAIL abort_fresh: count %0d bad %0d want 3 0", got_idx.size(), seq_bad(3)); end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      base_re = $urandom; base_im = $urandom; stride_re = $urandom; stride_im = $urandom;
      run_stream(n, 1, 0, -1, 600);
      checks++; if (got_idx.size() != n || seq_bad(n) != 0) begin errors++; $display("FAIL rand_seq: n %0d count %0d bad %0d", n, got_idx.size(), seq_bad(n)); end
      checks++; if (stall_bad != 0 || max_out > 2 || done_cnt != 1) begin errors++; $display("FAIL rand_proto: stalls %0d outstanding %0d done %0d want 0 <=2 1", stall_bad, max_out, done_cnt); end
    end
  endtask

  task automatic test_max();
    base_re = $urandom; base_im = $urandom; stride_re = 32'd1; stride_im = 32'd1;
    run_stream(4095, 0, 0, -1, 4300);
    checks++; if (got_idx.size() != 4095 || seq_bad(4095) != 0) begin errors++; $display("FAIL max_seq: count %0d bad %0d want 4095 0", got_idx.size(), seq_bad(4095)); end
    checks++; if (last_xfer_step - first_xfer_step != 4094) begin errors++; $display("FAIL max_throughput: got %0d want 4094", last_xfer_step - first_xfer_step); end
    checks++; if (done_cnt != 1 || addr_bad != 0) begin errors++; $display("FAIL max_done: done %0d addr_bad %0d want 1 0", done_cnt, addr_bad); end
  endtask

  initial begin
    clear_trackers();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_ce_gap();
    test_single();
    test_restart_ignored();
    test_abort();
    test_random();
    test_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
